// File: rtl/ws_pkg.sv
// Shared types and width/saturation helpers for the weight-stationary result drain.
package ws_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_e;

    function automatic int row_width(input int m);
        return ($clog2(m) > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int col_width(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int shift_width(input int dw);
        return $clog2(2 * dw);
    endfunction

    // Requantised results must fit a signed DATA_WIDTH operand.
    function automatic longint sat_hi(input int dw);
        return (longint'(1) <<< (dw - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/ws_result_drain_if.sv
// Valid/ready result stream from the drain to the writeback path.
interface ws_result_drain_if
    import ws_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 4,
    parameter int N          = 4
);
    localparam int RW = row_width(M);
    localparam int CW = col_width(N);

    logic                    m_valid;
    logic                    m_ready;
    logic [2*DATA_WIDTH-1:0] m_data;
    logic [RW-1:0]           m_row;
    logic [CW-1:0]           m_col;
    logic                    m_last;

    modport master (
        output m_valid,
        input  m_ready,
        output m_data,
        output m_row,
        output m_col,
        output m_last
    );

    modport slave (
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_row,
        input  m_col,
        input  m_last
    );

endinterface

// File: rtl/ws_requant.sv
// Combinational arithmetic right shift followed by saturation to a signed DATA_WIDTH range.
module ws_requant
    import ws_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [2*DATA_WIDTH-1:0]         acc_i,
    input  logic        [shift_width(DATA_WIDTH)-1:0] shift_i,
    output logic signed [2*DATA_WIDTH-1:0]         res_o
);
    localparam int AW = 2 * DATA_WIDTH;
    localparam logic signed [AW-1:0] SAT_HI = AW'(sat_hi(DATA_WIDTH));
    localparam logic signed [AW-1:0] SAT_LO = AW'(sat_lo(DATA_WIDTH));

    logic signed [AW-1:0] shifted;

    // Truncating shift; the clamped value is already sign-extended to full width.
    always_comb begin
        shifted = acc_i >>> shift_i;
        res_o   = shifted;
        if (shifted > SAT_HI) begin
            res_o = SAT_HI;
        end else if (shifted < SAT_LO) begin
            res_o = SAT_LO;
        end
    end

endmodule

// File: rtl/ws_result_drain.sv
// Snapshots the M x N accumulator matrix on capture and streams it out row-major.
// Optional requantisation of each element is enabled with `define WS_DRAIN_REQUANT_EN.
module ws_result_drain
    import ws_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 4,
    parameter int N          = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      capture_i,
    input  logic [0:M-1][0:N-1][2*DATA_WIDTH-1:0]     c_in,
    input  logic [shift_width(DATA_WIDTH)-1:0]        shift_i,
    ws_result_drain_if.master                         m_if,
    output logic                                      busy,
    output logic                                      overrun
);
    localparam int AW = 2 * DATA_WIDTH;
    localparam int RW = row_width(M);
    localparam int CW = col_width(N);
    localparam int SW = shift_width(DATA_WIDTH);

    drain_state_e                  state_q, state_d;
    logic [RW-1:0]                 row_q, row_d;
    logic [CW-1:0]                 col_q, col_d;
    logic [0:M-1][0:N-1][AW-1:0]   buf_q;
    logic                          overrun_q, overrun_d;
    logic                          loadBuf;
    logic                          xfer;
    logic                          lastIdx;
    logic                          streaming;
    logic [AW-1:0]                 rawElem;
    logic [AW-1:0]                 elemVal;

    assign streaming = (state_q == STREAM);
    assign xfer      = streaming && m_if.m_ready;
    assign lastIdx   = (row_q == RW'(M - 1)) && (col_q == CW'(N - 1));

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        loadBuf   = 1'b0;
        overrun_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (capture_i) begin
                    loadBuf = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // A capture is only safe when it coincides with the final transfer.
                if (xfer && lastIdx) begin
                    row_d = '0;
                    col_d = '0;
                    if (capture_i) begin
                        loadBuf = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    overrun_d = capture_i;
                    if (xfer) begin
                        if (col_q == CW'(N - 1)) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else if (loadBuf) begin
            buf_q <= c_in;
        end
    end

    assign rawElem = buf_q[row_q][col_q];

`ifdef WS_DRAIN_REQUANT_EN
    logic [SW-1:0] shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else if (loadBuf) begin
            shift_q <= shift_i;
        end
    end

    ws_requant #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_requant (
        .acc_i   (rawElem),
        .shift_i (shift_q),
        .res_o   (elemVal)
    );
`else
    // The shift amount has no effect without requantisation.
    logic unused_shift;
    assign unused_shift = ^{shift_i, SW'(0)};
    assign elemVal      = rawElem;
`endif

    assign m_if.m_valid = streaming;
    assign m_if.m_data  = streaming ? elemVal : '0;
    assign m_if.m_row   = streaming ? row_q : '0;
    assign m_if.m_col   = streaming ? col_q : '0;
    assign m_if.m_last  = streaming && lastIdx;
    assign busy         = streaming;
    assign overrun      = overrun_q;

endmodule
